mems_scan_sequencer: RTL and testbench
======================================

Name: mems_scan_sequencer

Overview:
Parametrised successor to the fixed-geometry MEMS DAC controller. Issues the MEMS DAC initialisation command sequence, then walks the scan-pattern ROM address space point by point, handshaking each word with the MEMS SPI master. Line and frame boundaries come from counters rather than hard-coded addresses, and are flagged to the FIFO/readout logic. Adds single-shot/continuous mode, soft re-init from scan, and simultaneous flag set/clear resolution.

Parameters:
ADDR_W, 16, ROM address width
INIT_CMDS, 2, number of init commands at ROM addresses 0..INIT_CMDS-1 (>=1)
SCAN_BASE, 8, ROM address of first scan point (>= INIT_CMDS)
POINTS_PER_LINE, 720, scan points per line (>=2)
LINES_PER_FRAME, 3, lines per frame (>=1)
NUM_FRAMES, 6, frames in ROM before wrap (>=1); SCAN_BASE+POINTS_PER_LINE*LINES_PER_FRAME*NUM_FRAMES must fit in ADDR_W

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
pause  in  1  hold scan; no new SCAN transaction while high
continuous  in  1  1 = wrap at end of ROM; 0 = stop after last point (sampled at wrap decision)
mems_SPI_busy  in  1  SPI master busy
mems_soft_reset  in  1  request (re)initialisation
new_line_FIFO_done  in  1  acknowledge, clears new_line
new_frame_FIFO_done  in  1  acknowledge, clears new_frame
mems_SPI_start  out  1  one-cycle transaction start strobe
addr  out  ADDR_W  ROM address; valid when mems_SPI_start is high, held until next start
new_line  out  1  sticky line-boundary flag
new_frame  out  1  sticky frame-boundary flag
scan_done  out  1  high in DONE state
frame_idx  out  clog2(NUM_FRAMES)+1  index of frame currently being sent

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; addr=0; mems_SPI_start=0; new_line=new_frame=0; scan_done=0; frame_idx=0; all counters 0.
- ready = !mems_SPI_busy && !mems_SPI_start (registered). Start pulses are at least 2 cycles apart, which gives the SPI master one cycle to raise busy.
- IDLE: addr=0. On mems_soft_reset: start=1, addr=0, go to INIT.
- INIT: on ready, if init index < INIT_CMDS-1: addr+1, start. Else addr=SCAN_BASE, counters cleared, start, go to SCAN. Init ignores pause.
- SCAN: on ready && !pause, issue next point (start=1) and update point/line/frame counters:
  - Point not last in line: addr+1.
  - Last point of a line that is not last in frame: addr+1; set new_line.
  - Last point of a frame that is not last in ROM: addr+1; set new_frame only (new_line not set); frame_idx+1.
  - Last point of ROM with continuous=1: addr=SCAN_BASE, frame_idx=0, set new_frame, start.
  - Last point of ROM with continuous=0: no start; set new_frame; go to DONE.
  - Flags are set in the same cycle that start is asserted for the first point of the new line/frame.
- mems_soft_reset in SCAN or DONE: takes effect at the next ready cycle (an in-flight transaction is never aborted). It has priority over a scan advance: start, addr=0, go to INIT, flags unchanged.
- DONE: scan_done=1, no strobes, addr held. mems_soft_reset -> INIT as above.
- Flags: a *_FIFO_done clears its flag next cycle. Set and done in the same cycle: set wins (flag stays 1). A set while the flag is already 1 leaves it at 1 (no counting).
- pause does not affect flag clearing.
- Illegal state encoding -> IDLE.

Optional Feature:
MEMS_SCAN_SERPENTINE_EN: when defined, odd lines within each frame are sent in reverse address order. The line's first point is its highest address; within the line addr decrements; the line boundary jumps to the lowest address of the next line. Boundary flags, counters and frame_idx are identical to raster mode. Not defined: raster order only, and no reverse-address logic is synthesised.

Test Plan:
- Init: params INIT_CMDS=2, SCAN_BASE=8, POINTS_PER_LINE=4, LINES_PER_FRAME=3, NUM_FRAMES=2; busy held 3 cycles per transaction; pulse soft_reset -> start strobes with addr 0, 1, 8, in order, each separated by at least the busy window.
- Line/frame flags: continue from previous -> new_line set with addr 12 and with addr 16; new_frame (not new_line) set with addr 20 and frame_idx=1; no done inputs -> flags stay 1.
- Continuous wrap: continuous=1 -> after addr 31, next start has addr=8, new_frame=1, frame_idx=0. With continuous=0 -> no start after 31, scan_done=1, addr holds 31.
- Flag race: new_line already 1, new_line_FIFO_done asserted in the same cycle new_line is set -> new_line remains 1. Done alone on the next cycle -> 0.
- Pause/reset: pause=1 mid-line -> no strobes, addr holds. Soft_reset while busy -> waits for busy low, then start with addr=0 and INIT. rst_n=0 mid-scan -> all outputs at reset values next cycle.
- Serpentine (macro defined): line 1 of frame 0 emits addr 15, 14, 13, 12; then 16, 17, ...

Source files
------------

// File: rtl/mems_scan_sequencer.sv
// mems_scan_sequencer: MEMS DAC init then counter-driven scan-ROM walk with line/frame flags.
// Optional reverse-order odd lines when MEMS_SCAN_SERPENTINE_EN is defined.
module mems_scan_sequencer #(
    parameter int ADDR_W          = 16,
    parameter int INIT_CMDS       = 2,
    parameter int SCAN_BASE       = 8,
    parameter int POINTS_PER_LINE = 720,
    parameter int LINES_PER_FRAME = 3,
    parameter int NUM_FRAMES      = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              pause,
    input  logic                              continuous,
    input  logic                              mems_SPI_busy,
    input  logic                              mems_soft_reset,
    input  logic                              new_line_FIFO_done,
    input  logic                              new_frame_FIFO_done,
    output logic                              mems_SPI_start,
    output logic [ADDR_W-1:0]                 addr,
    output logic                              new_line,
    output logic                              new_frame,
    output logic                              scan_done,
    output logic [$clog2(NUM_FRAMES):0]       frame_idx
);
    localparam int FW = $clog2(NUM_FRAMES) + 1;
    localparam int PW = $clog2(POINTS_PER_LINE);
    localparam int LW = $clog2(LINES_PER_FRAME + 1);
    localparam int IW = $clog2(INIT_CMDS + 1);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(SCAN_BASE);
    localparam logic [PW-1:0]     PT_LAST = PW'(POINTS_PER_LINE - 1);
    localparam logic [LW-1:0]     LN_LAST = LW'(LINES_PER_FRAME - 1);
    localparam logic [FW-1:0]     FR_LAST = FW'(NUM_FRAMES - 1);
    localparam logic [IW-1:0]     II_LAST = IW'(INIT_CMDS - 1);

    typedef enum logic [1:0] {IDLE, INIT, SCAN, DONE} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     init_idx, init_idx_n;
    logic [PW-1:0]     pt, pt_n;
    logic [LW-1:0]     ln, ln_n;
    logic [FW-1:0]     fr_n;
    logic [ADDR_W-1:0] addr_n;
    logic              start_n, set_line, set_frame, ready;
    logic              pt_last, ln_last, fr_last, wrap;
`ifdef MEMS_SCAN_SERPENTINE_EN
    localparam logic [ADDR_W-1:0] PPL_A = ADDR_W'(POINTS_PER_LINE);
    logic [ADDR_W-1:0] lbase, lbase_n;
`endif

    assign scan_done = state == DONE;

    always_comb begin
        state_n    = state;
        init_idx_n = init_idx;
        pt_n       = pt;
        ln_n       = ln;
        fr_n       = frame_idx;
        addr_n     = addr;
        start_n    = 1'b0;
        set_line   = 1'b0;
        set_frame  = 1'b0;
`ifdef MEMS_SCAN_SERPENTINE_EN
        lbase_n    = lbase;
`endif
        ready   = !mems_SPI_busy && !mems_SPI_start;
        pt_last = pt == PT_LAST;
        ln_last = ln == LN_LAST;
        fr_last = frame_idx == FR_LAST;
        wrap    = pt_last && ln_last && fr_last;
        case (state)
            IDLE: begin
                addr_n = '0;
                if (mems_soft_reset) begin
                    start_n    = 1'b1;
                    init_idx_n = '0;
                    state_n    = INIT;
                end
            end
            INIT: if (ready) begin
                start_n = 1'b1;
                if (init_idx < II_LAST) begin
                    init_idx_n = init_idx + 1'b1;
                    addr_n     = addr + 1'b1;
                end else begin
                    addr_n  = BASE_A;
                    pt_n    = '0;
                    ln_n    = '0;
                    fr_n    = '0;
                    state_n = SCAN;
`ifdef MEMS_SCAN_SERPENTINE_EN
                    lbase_n = BASE_A;
`endif
                end
            end
            SCAN, DONE: begin
                // soft re-init wins over a scan advance but never cuts an in-flight word
                if (ready && mems_soft_reset) begin
                    start_n    = 1'b1;
                    addr_n     = '0;
                    init_idx_n = '0;
                    state_n    = INIT;
                end else if (state == SCAN && ready && !pause) begin
                    pt_n      = pt_last ? '0 : pt + 1'b1;
                    ln_n      = !pt_last ? ln : ln_last ? '0 : ln + 1'b1;
                    fr_n      = !(pt_last && ln_last) ? frame_idx :
                                fr_last ? (continuous ? '0 : frame_idx) : frame_idx + 1'b1;
                    set_line  = pt_last && !ln_last;
                    set_frame = pt_last && ln_last;
                    start_n   = !(wrap && !continuous);
                    state_n   = (wrap && !continuous) ? DONE : SCAN;
`ifdef MEMS_SCAN_SERPENTINE_EN
                    lbase_n   = !pt_last ? lbase : wrap ? BASE_A : lbase + PPL_A;
                    addr_n    = (wrap && !continuous) ? addr :
                                pt_last ? (ln_n[0] ? lbase_n + PPL_A - 1'b1 : lbase_n) :
                                ln[0] ? addr - 1'b1 : addr + 1'b1;
`else
                    addr_n    = wrap ? (continuous ? BASE_A : addr) : addr + 1'b1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            init_idx       <= '0;
            pt             <= '0;
            ln             <= '0;
            frame_idx      <= '0;
            addr           <= '0;
            mems_SPI_start <= 1'b0;
            new_line       <= 1'b0;
            new_frame      <= 1'b0;
`ifdef MEMS_SCAN_SERPENTINE_EN
            lbase          <= '0;
`endif
        end else begin
            state          <= state_n;
            init_idx       <= init_idx_n;
            pt             <= pt_n;
            ln             <= ln_n;
            frame_idx      <= fr_n;
            addr           <= addr_n;
            mems_SPI_start <= start_n;
            new_line       <= set_line || (new_line && !new_line_FIFO_done);
            new_frame      <= set_frame || (new_frame && !new_frame_FIFO_done);
`ifdef MEMS_SCAN_SERPENTINE_EN
            lbase          <= lbase_n;
`endif
        end
    end
endmodule

// File: tb/tb_mems_scan_sequencer.sv
// tb_mems_scan_sequencer: random stimulus against a point-index reference model.
module tb_mems_scan_sequencer;
    localparam int AW = 16, INIT = 2, SB = 8, PPL = 4, LPF = 3, NF = 2;
    localparam int TOT = PPL * LPF * NF;
    localparam int FW = $clog2(NF) + 1;

    logic clk = 1'b0;
    logic rst_n, pause, continuous, mems_SPI_busy, mems_soft_reset;
    logic new_line_FIFO_done, new_frame_FIFO_done;
    logic mems_SPI_start, new_line, new_frame, scan_done;
    logic [AW-1:0] addr;
    logic [FW-1:0] frame_idx;

    int tests = 0, fails = 0;
    int m_mode, m_ii, m_n, m_frame, m_addr, bcnt, lat;
    bit m_start, m_nl, m_nf, rdy, ns, sl, sf;

    always #5 clk = ~clk;

    mems_scan_sequencer #(
        .ADDR_W(AW), .INIT_CMDS(INIT), .SCAN_BASE(SB),
        .POINTS_PER_LINE(PPL), .LINES_PER_FRAME(LPF), .NUM_FRAMES(NF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pause(pause), .continuous(continuous),
        .mems_SPI_busy(mems_SPI_busy), .mems_soft_reset(mems_soft_reset),
        .new_line_FIFO_done(new_line_FIFO_done), .new_frame_FIFO_done(new_frame_FIFO_done),
        .mems_SPI_start(mems_SPI_start), .addr(addr), .new_line(new_line),
        .new_frame(new_frame), .scan_done(scan_done), .frame_idx(frame_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ROM address of the n-th scan point counted from the first point of frame 0
    function automatic int pa(input int n);
        int line = n / PPL;
        int p = n % PPL;
`ifdef MEMS_SCAN_SERPENTINE_EN
        if ((line % LPF) % 2 == 1) p = PPL - 1 - p;
`endif
        return SB + line * PPL + p;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_mode = 0; m_ii = 0; m_n = 0; m_frame = 0; m_addr = 0;
            m_start = 0; m_nl = 0; m_nf = 0;
            return;
        end
        rdy = !mems_SPI_busy && !m_start;
        ns = 0; sl = 0; sf = 0;
        case (m_mode)
            0: begin
                m_addr = 0;
                if (mems_soft_reset) begin ns = 1; m_ii = 0; m_mode = 1; end
            end
            1: if (rdy) begin
                ns = 1;
                if (m_ii < INIT - 1) begin m_ii++; m_addr = m_ii; end
                else begin m_mode = 2; m_n = 0; m_frame = 0; m_addr = pa(0); end
            end
            default: begin
                if (rdy && mems_soft_reset) begin
                    ns = 1; m_addr = 0; m_ii = 0; m_mode = 1;
                end else if (m_mode == 2 && rdy && !pause) begin
                    if (m_n == TOT - 1) begin
                        sf = 1;
                        if (continuous) begin ns = 1; m_n = 0; m_frame = 0; m_addr = pa(0); end
                        else m_mode = 3;
                    end else begin
                        m_n++; ns = 1; m_addr = pa(m_n);
                        if (m_n % PPL == 0) begin
                            if ((m_n / PPL) % LPF == 0) begin sf = 1; m_frame = m_n / (PPL * LPF); end
                            else sl = 1;
                        end
                    end
                end
            end
        endcase
        m_nl = sl || (m_nl && !new_line_FIFO_done);
        m_nf = sf || (m_nf && !new_frame_FIFO_done);
        m_start = ns;
    endtask

    initial begin
        rst_n = 0; pause = 0; continuous = 0; mems_SPI_busy = 0; mems_soft_reset = 0;
        new_line_FIFO_done = 0; new_frame_FIFO_done = 0; bcnt = 0;
        model_step();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            check("start", 32'(mems_SPI_start), 32'(m_start));
            check("addr", 32'(addr), 32'(m_addr));
            check("new_line", 32'(new_line), 32'(m_nl));
            check("new_frame", 32'(new_frame), 32'(m_nf));
            check("scan_done", 32'(scan_done), 32'(m_mode == 3));
            check("frame_idx", 32'(frame_idx), 32'(m_frame));
            lat = cyc < 400 ? 3 : int'($urandom_range(1, 4));
            if (mems_SPI_start) bcnt = lat;
            else if (bcnt > 0) bcnt--;
            mems_SPI_busy = bcnt != 0;
            if (cyc < 3) rst_n = 0;
            else if (cyc < 400) begin
                rst_n = 1; mems_soft_reset = cyc == 5; pause = 0; continuous = cyc < 300;
                new_line_FIFO_done = 0; new_frame_FIFO_done = 0;
            end else begin
                rst_n = $urandom_range(0, 999) != 0;
                mems_soft_reset = $urandom_range(0, 149) == 0;
                pause = $urandom_range(0, 3) == 0;
                continuous = $urandom_range(0, 3) != 0;
                new_line_FIFO_done = $urandom_range(0, 4) == 0;
                new_frame_FIFO_done = $urandom_range(0, 4) == 0;
            end
            model_step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
